// File: rtl/out_byte_uart_tx_pkg.sv
// Shared definitions for the out_byte console UART transmitter:
// FSM state encoding, frame constants and divider-width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;

  // Bits needed to count 0..div-1; never less than one bit.
  function automatic int ctr_width(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/out_byte_uart_tx_if.sv
// Console-port bundle: byte strobe from the CPU side plus serial/status outputs.
// No handshake: in_byte is consumed on every edge where in_byte_en=1 (no ready).
interface out_byte_uart_tx_if #(
  parameter int FIFO_DEPTH_LOG2 = 4
);
  import uart_pkg::*;

  logic [7:0]               in_byte;
  logic                     in_byte_en;
  logic                     tx;
  logic                     busy;
  logic                     overflow;
  logic [FIFO_DEPTH_LOG2:0] fifo_level;
  uart_state_e              fsm_state;

  modport master (
    output in_byte, in_byte_en,
    input  tx, busy, overflow, fifo_level, fsm_state
  );

  modport slave (
    input  in_byte, in_byte_en,
    output tx, busy, overflow, fifo_level, fsm_state
  );

endinterface

// File: rtl/out_byte_uart_tx_byte_fifo.sv
// First-word-fall-through byte FIFO; pointers carry an extra wrap bit so
// full and empty are distinguishable without a separate counter.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [7:0]          din,
  input  logic                pop,
  output logic [7:0]          dout,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (DEPTH_LOG2+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (DEPTH_LOG2+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (DEPTH_LOG2+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/out_byte_uart_tx.sv
// 8N1 serial transmitter for the out_byte console port, fed through a byte
// FIFO; exposes overflow and fill level so dropped characters are visible.
module out_byte_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV         = 434,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input logic               clk,
  input logic               reset,
  out_byte_uart_tx_if.slave bus
);

  localparam int                DIV_W    = ctr_width(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]        BIT_LAST = 3'(DATA_BITS - 1);

  uart_state_e              state;
  logic [DIV_W-1:0]         div_cnt;
  logic [2:0]               bit_idx;
  logic [7:0]               shift;
  logic                     tx_q;
  logic                     overflow_q;

  logic                     div_done;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [7:0]               fifo_dout;
  logic [FIFO_DEPTH_LOG2:0] fifo_level;

  assign div_done = (div_cnt == DIV_LAST);

  // Pops only where a new frame begins: leaving IDLE, or the last STOP cycle.
  assign fifo_pop  = !fifo_empty && ((state == IDLE) || (state == STOP && div_done));
  assign fifo_push = bus.in_byte_en && (!fifo_full || fifo_pop);

  byte_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (bus.in_byte),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (bus.in_byte_en && fifo_full && !fifo_pop) overflow_q <= 1'b1;

      case (state)
        IDLE: begin
          tx_q    <= 1'b1;
          div_cnt <= '0;
          if (fifo_pop) begin
            shift   <= fifo_dout;
            bit_idx <= '0;
            tx_q    <= 1'b0;
            state   <= START;
          end
        end

        START: begin
          if (div_done) begin
            div_cnt <= '0;
            tx_q    <= shift[0];
            state   <= DATA;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        DATA: begin
          if (div_done) begin
            div_cnt <= '0;
            shift   <= {1'b0, shift[7:1]};
            if (bit_idx == BIT_LAST) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              tx_q    <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        STOP: begin
          if (div_done) begin
            div_cnt <= '0;
            if (fifo_pop) begin
              shift   <= fifo_dout;
              bit_idx <= '0;
              tx_q    <= 1'b0;
              state   <= START;
            end else begin
              tx_q  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: begin
          tx_q  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_level = fifo_level;
  assign bus.busy       = (state != IDLE) || (fifo_level != '0);
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_out_byte_uart_tx.sv
// Directed bench for out_byte_uart_tx at CLK_DIV=4 with a 4-entry FIFO:
// per-cycle frame tables plus a serial-decoding scoreboard for multi-frame cases.
module tb_out_byte_uart_tx;
  import uart_pkg::*;

  localparam int TB_DIV  = 4;
  localparam int TB_DLOG = 2;

  logic clk;
  logic reset;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  out_byte_uart_tx_if #(.FIFO_DEPTH_LOG2(TB_DLOG)) bus ();

  out_byte_uart_tx #(
    .CLK_DIV         (TB_DIV),
    .FIFO_DEPTH_LOG2 (TB_DLOG)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    bus.in_byte_en = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    reset = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // Strobes first..first+n-1 on consecutive edges; returns half a cycle after the last.
  task automatic push_burst(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_byte    = first + 8'(i);
      bus.in_byte_en = 1'b1;
    end
    @(negedge clk);
    bus.in_byte_en = 1'b0;
  endtask

  task automatic check_frame(input logic [9:0] f, input bit first_now);
    for (int i = 0; i < 10 * TB_DIV; i++) begin
      if (!(i == 0 && first_now)) @(negedge clk);
      chk("frame_tx", 32'(bus.tx), 32'(f[i / TB_DIV]));
      chk("frame_busy", 32'(bus.busy), 32'd1);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_busy", 32'(bus.busy), 32'd0);
  endtask

  // ---------------- scoreboard: serial decoder ----------------
  initial begin : rx_monitor
    logic [7:0] rx;
    logic       start_ok;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.tx === 1'b0) begin
        aborted = 1'b0;
        rx      = '0;
        @(negedge clk);
        if (reset) aborted = 1'b1;
        start_ok = ~bus.tx;
        for (int k = 0; k < 8; k++) begin
          repeat (TB_DIV) begin
            @(negedge clk);
            if (reset) aborted = 1'b1;
          end
          rx[k] = bus.tx;
        end
        repeat (TB_DIV) begin
          @(negedge clk);
          if (reset) aborted = 1'b1;
        end
        if (!aborted) begin
          chk("rx_start_bit", 32'(start_ok), 32'd1);
          chk("rx_stop_bit", 32'(bus.tx), 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rx_unexpected: got %0h expected no frame", rx);
          end else begin
            chk("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  // ---------------- directed test ----------------
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // bit 0 leaves first: {stop, d7..d0, start}
  } vec_t;

  vec_t vecs[4];

  initial begin : main
    bit stayed_high;

    vecs[0] = '{data: 8'h55, frame: 10'b1010101010};
    vecs[1] = '{data: 8'h00, frame: 10'b1000000000};
    vecs[2] = '{data: 8'hFF, frame: 10'b1111111110};
    vecs[3] = '{data: 8'h3C, frame: 10'b1001111000};

    reset          = 1'b1;
    bus.in_byte    = 8'h00;
    bus.in_byte_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(bus.tx), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_level", 32'(bus.fifo_level), 32'd0);
    chk("rst_state", 32'(bus.fsm_state), 32'(IDLE));
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_tx", 32'(bus.tx), 32'd1);

    // single frames, checked cycle by cycle
    for (int v = 0; v < 4; v++) begin
      exp_q.push_back(vecs[v].data);
      push_burst(vecs[v].data, 1);
      chk("single_level", 32'(bus.fifo_level), 32'd1);
      chk("single_busy", 32'(bus.busy), 32'd1);
      check_frame(vecs[v].frame, 1'b0);
      @(negedge clk);
      chk("single_end_busy", 32'(bus.busy), 32'd0);
      chk("single_end_tx", 32'(bus.tx), 32'd1);
    end

    // back-to-back: second start bit directly after first stop bit
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h0F);
    @(negedge clk);
    bus.in_byte = 8'hA5; bus.in_byte_en = 1'b1;
    @(negedge clk);
    chk("b2b_level_a", 32'(bus.fifo_level), 32'd1);
    bus.in_byte = 8'h0F;
    @(negedge clk);
    bus.in_byte_en = 1'b0;
    chk("b2b_level_b", 32'(bus.fifo_level), 32'd1);
    check_frame(10'b1101001010, 1'b1);
    check_frame(10'b1000011110, 1'b0);
    @(negedge clk);
    chk("b2b_end_busy", 32'(bus.busy), 32'd0);
    chk("b2b_rx_drain", 32'(exp_q.size()), 32'd0);

    // overflow: sixth strobe lands on a full FIFO with no pop
    do_reset();
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    push_burst(8'h01, 6);
    chk("ovf_level", 32'(bus.fifo_level), 32'd4);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    wait_idle(600);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    chk("ovf_level_drained", 32'(bus.fifo_level), 32'd0);
    chk("ovf_rx_drain", 32'(exp_q.size()), 32'd0);

    // push into a full FIFO on the STOP->START pop edge
    do_reset();
    for (int i = 0; i < 6; i++) exp_q.push_back(8'h80 + 8'(i));
    push_burst(8'h80, 5);
    chk("fullpop_fill", 32'(bus.fifo_level), 32'd4);
    repeat (36) @(negedge clk);
    chk("fullpop_state", 32'(bus.fsm_state), 32'(STOP));
    bus.in_byte = 8'h85; bus.in_byte_en = 1'b1;
    chk("fullpop_level_pre", 32'(bus.fifo_level), 32'd4);
    @(negedge clk);
    bus.in_byte_en = 1'b0;
    chk("fullpop_level_post", 32'(bus.fifo_level), 32'd4);
    chk("fullpop_overflow", 32'(bus.overflow), 32'd0);
    wait_idle(800);
    chk("fullpop_overflow_end", 32'(bus.overflow), 32'd0);
    chk("fullpop_rx_drain", 32'(exp_q.size()), 32'd0);

    // reset during DATA bit 3 with two bytes queued
    do_reset();
    exp_q.push_back(8'h70);
    push_burst(8'h70, 3);
    chk("midrst_level", 32'(bus.fifo_level), 32'd2);
    repeat (16) @(negedge clk);
    chk("midrst_state", 32'(bus.fsm_state), 32'(DATA));
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_tx", 32'(bus.tx), 32'd1);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_level0", 32'(bus.fifo_level), 32'd0);
    chk("midrst_overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    stayed_high = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) stayed_high = 1'b0;
    end
    chk("midrst_tx_quiet", 32'(stayed_high), 32'd1);

    // wrap-around: 12 bytes through a 4-entry FIFO, level kept at 3 or below
    for (int i = 0; i < 12; i++) exp_q.push_back(8'h10 + 8'(i));
    push_burst(8'h10, 3);
    chk("wrap_level", 32'(bus.fifo_level <= 3), 32'd1);
    for (int i = 3; i < 12; i++) begin
      repeat (40) @(negedge clk);
      push_burst(8'h10 + 8'(i), 1);
      chk("wrap_level", 32'(bus.fifo_level <= 3), 32'd1);
    end
    wait_idle(1000);
    chk("wrap_overflow", 32'(bus.overflow), 32'd0);
    chk("wrap_rx_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/out_byte_uart_tx.md
Name: out_byte_uart_tx

Overview:
- Downstream consumer of the system's `out_byte`/`out_byte_en` console port.
- Turns each single-cycle byte strobe into an 8N1 serial frame on one TX pin.
- The CPU port has no backpressure, so a small byte FIFO absorbs bursts of stores.
- An overflow flag and a fill level let the testbench or board logic detect lost characters.

Parameters:
- CLK_DIV, 434, clock cycles per serial bit (e.g. 50 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH_LOG2, 4, log2 of FIFO depth in bytes (16 entries); legal range 1..8.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_byte  in  8  byte to transmit; valid only when in_byte_en=1.
- in_byte_en  in  1  single-cycle write strobe; no ready/backpressure.
- tx  out  1  serial output; idles high.
- busy  out  1  high while a frame is on the wire or the FIFO is non-empty.
- overflow  out  1  sticky; set when a strobe is dropped because the FIFO is full.
- fifo_level  out  FIFO_DEPTH_LOG2+1  current FIFO occupancy.

Behaviour:
- One clock (`clk`); reset is synchronous and active-high.
- Reset values: tx=1, busy=0, overflow=0, fifo_level=0; FSM=IDLE; bit counter and divider counter = 0. Reset mid-frame aborts the frame, drives tx high on the next edge and discards FIFO contents.
- FIFO write (push):
  - On an edge with in_byte_en=1, in_byte is pushed if level<depth.
  - It is also pushed if level==depth and a pop occurs on the same edge.
  - Otherwise the byte is dropped and overflow is set to 1; it stays 1 until reset.
- FIFO read: the FIFO is first-word-fall-through.
  - A pop happens only on the IDLE->START transition, or on STOP->START for back-to-back frames.
  - The popped byte is loaded into the 8-bit shift register.
- fifo_level increments on push only, decrements on pop only, and is unchanged on simultaneous push+pop.
- FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop, clear the divider and go to START.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLK_DIV cycles per bit, LSB first. After each bit, shift right and increment the index. After bit 7, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. At the end of STOP:
    - If the FIFO is non-empty, pop and go directly to START (no extra idle cycle).
    - Otherwise go to IDLE.
- Divider: counts 0..CLK_DIV-1; the terminal count advances the bit. The counter width is sized from CLK_DIV.
- Latency: a strobe sampled at edge E0 into an empty FIFO with the FSM in IDLE:
  - the pop occurs at edge E0+1;
  - tx falls at edge E0+1 (registered output of the START state);
  - the frame is exactly 10*CLK_DIV cycles;
  - back-to-back frames are contiguous.
- busy = (state!=IDLE) || (fifo_level!=0), registered consistently with state.
- tx is a registered output with no combinational path from the inputs.

Decomposition:
- Shared package `uart_pkg`:
  - FSM state enum {IDLE, START, DATA, STOP};
  - constant DATA_BITS=8;
  - a function returning the counter width for CLK_DIV.
- Sub-module `byte_fifo`: synchronous FIFO, parameter DEPTH_LOG2.
  - Ports: clk, reset, push, din, pop, dout, full, empty, level.
  - Implemented as a register array with wrap-around pointers one bit wider than the address.
- The top level holds the divider, shift register, FSM and overflow flag.

Test Plan:
- Single byte, CLK_DIV=4: strobe in_byte=0x55 once -> tx low 4 cycles starting one edge after the strobe, then data 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles. busy stays high for the whole 40-cycle frame and returns to 0 after STOP.
- Back-to-back, CLK_DIV=4: strobe 0xA5 then 0x0F on consecutive cycles -> two contiguous 40-cycle frames. The start bit of the second frame follows the stop bit of the first with no idle cycle. fifo_level peaks at 1.
- Overflow, FIFO_DEPTH_LOG2=2, CLK_DIV=4: six strobes on consecutive cycles with values 0x01..0x06:
  - 0x01 is popped at once; 0x02..0x05 are stored and fifo_level reaches 4;
  - 0x06 is dropped and overflow=1;
  - the frames 0x01..0x05 are emitted in order;
  - overflow stays 1 after the FIFO drains.
- Push while full with simultaneous pop: fill the FIFO to 4, then strobe exactly at the edge where STOP->START pops -> the byte is accepted, overflow stays 0, fifo_level stays 4.
- Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued -> on the next edge tx=1, busy=0, fifo_level=0, overflow=0. After reset is released with no strobe, tx stays high.
- Wrap-around, FIFO_DEPTH_LOG2=2: stream 12 bytes 0x10..0x1B, keeping level ≤3 -> all 12 frames decode correctly and in order; pointers wrap 3 times with no loss.
